// File: rtl/polar_pkg.sv
// Shared types and helpers for the folded polar Kronecker encoder.
// Holds the FSM state enum, clog2, index bit reversal and default sizes.
package polar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MAX_LOG2N_DEF   = 8;
    localparam int STG_PER_CYC_DEF = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < v) r = b + 1;
        end
        return r;
    endfunction

    // Reverse the low ln bits of idx.
    function automatic int rev_bits(input int idx, input int ln);
        int r;
        r = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < ln) r = r | (((idx >> b) & 1) << (ln - 1 - b));
        end
        return r;
    endfunction

    function automatic int nmax_of(input int max_log2n);
        return 1 << max_log2n;
    endfunction

    // Stage counter must hold s + STG_PER_CYC past the largest ln.
    function automatic int scw_of(input int max_log2n, input int spc);
        return clog2(max_log2n + spc + 1);
    endfunction

    localparam int NMAX_DEF = nmax_of(MAX_LOG2N_DEF);
    localparam int SCW_DEF  = scw_of(MAX_LOG2N_DEF, STG_PER_CYC_DEF);

endpackage

// File: rtl/polar_kron_stage.sv
// One combinational butterfly stage k of the polar transform.
// Ports: x in, k stage index, en enable, y = x with stage k applied (or x).
module polar_kron_stage
    import polar_pkg::*;
#(
    parameter int NMAX = 256,
    parameter int KW   = 4
) (
    input  logic [NMAX-1:0] x,
    input  logic [KW-1:0]   k,
    input  logic            en,
    output logic [NMAX-1:0] y
);

    localparam int LN = clog2(NMAX);

    // One fixed-wiring stage per possible k, selected by k.
    always_comb begin
        y = x;
        for (int kk = 0; kk < LN; kk++) begin
            if (en && (int'(k) == kk)) begin
                for (int i = 0; i < NMAX; i++) begin
                    if (i[kk]) y[i] = x[i] ^ x[i - (1 << kk)];
                end
            end
        end
    end

endmodule

// File: rtl/polar_kron_iter.sv
// Folded polar encoder x = u*F^(kron n), STG_PER_CYC stages per clock.
// Ports: vld_i/rdy_i/log2n_i/brv_i/din in side, dout/vld_o/rdy_o out side.
module polar_kron_iter
    import polar_pkg::*;
#(
    parameter int MAX_LOG2N   = 8,
    parameter int STG_PER_CYC = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              vld_i,
    output logic                              rdy_i,
    input  logic [clog2(MAX_LOG2N+1)-1:0]     log2n_i,
    input  logic                              brv_i,
    input  logic [(1<<MAX_LOG2N)-1:0]         din,
    output logic [(1<<MAX_LOG2N)-1:0]         dout,
    output logic                              vld_o,
    input  logic                              rdy_o
);

    localparam int NMAX = nmax_of(MAX_LOG2N);
    localparam int LW   = clog2(MAX_LOG2N + 1);
    localparam int SW   = scw_of(MAX_LOG2N, STG_PER_CYC);
    localparam logic [LW-1:0] LN_MAX = LW'(MAX_LOG2N);

    state_t          state, state_d;
    logic [SW-1:0]   s, s_d, s_nxt, ln_w;
    logic [LW-1:0]   ln_q, ln_d, ln_in;
    logic            brv_q, brv_d, vld_d;
    logic [NMAX-1:0] x, x_d, dout_d, mask, rv;
    logic [NMAX-1:0] xs [STG_PER_CYC+1];

    assign ln_in = (log2n_i > LN_MAX) ? LN_MAX : log2n_i;
    assign ln_w  = SW'(ln_q);
    assign s_nxt = s + SW'(STG_PER_CYC);
    assign rdy_i = (state == IDLE) | ((state == DONE) & rdy_o);

    assign xs[0] = x;

    // Stage s+j is only applied while it is below the latched ln.
    for (genvar j = 0; j < STG_PER_CYC; j++) begin : g_stg
        polar_kron_stage #(
            .NMAX (NMAX),
            .KW   (SW)
        ) u_stg (
            .x  (xs[j]),
            .k  (s + SW'(j)),
            .en ((s + SW'(j)) < ln_w),
            .y  (xs[j+1])
        );
    end

    // Keep only the low 2^ln bits of the incoming word.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NMAX; i++) begin
            mask[i] = ((i >> ln_in) == 0);
        end
    end

    // Bit-reversed view of the final stage output for the latched ln.
    always_comb begin
        rv = '0;
        for (int l = 0; l <= MAX_LOG2N; l++) begin
            if (int'(ln_q) == l) begin
                for (int i = 0; i < (1 << l); i++) begin
                    rv[rev_bits(i, l)] = xs[STG_PER_CYC][i];
                end
            end
        end
    end

    always_comb begin
        state_d = state;
        s_d     = s;
        ln_d    = ln_q;
        brv_d   = brv_q;
        x_d     = x;
        dout_d  = dout;
        vld_d   = vld_o;
        unique case (state)
            IDLE: ;
            RUN: begin
                x_d = xs[STG_PER_CYC];
                s_d = s_nxt;
                if (s_nxt >= ln_w) begin
                    state_d = DONE;
                    vld_d   = 1'b1;
                    dout_d  = brv_q ? rv : xs[STG_PER_CYC];
                end
            end
            DONE: begin
                if (rdy_o) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // An accept overrides the idle/done exit.
        if (vld_i && rdy_i) begin
            state_d = RUN;
            x_d     = din & mask;
            ln_d    = ln_in;
            brv_d   = brv_i;
            s_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s     <= '0;
            ln_q  <= '0;
            brv_q <= 1'b0;
            x     <= '0;
            dout  <= '0;
            vld_o <= 1'b0;
        end else begin
            state <= state_d;
            s     <= s_d;
            ln_q  <= ln_d;
            brv_q <= brv_d;
            x     <= x_d;
            dout  <= dout_d;
            vld_o <= vld_d;
        end
    end

endmodule

// File: tb/tb_polar_kron_iter.sv
// Self-checking bench for polar_kron_iter (SPC=2 and SPC=3 instances).
// Reference: x_j = XOR of u_i over all i whose bits are a subset of j.
module tb_polar_kron_iter;

    localparam int NM = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vld_i;
    logic [3:0]    log2n_i;
    logic          brv_i;
    logic [NM-1:0] din;
    logic          rdy_o;
    logic          rdy_i, vld_o, rdy_i3, vld_o3;
    logic [NM-1:0] dout, dout3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    polar_kron_iter #(.MAX_LOG2N(8), .STG_PER_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .rdy_i(rdy_i),
        .log2n_i(log2n_i), .brv_i(brv_i), .din(din),
        .dout(dout), .vld_o(vld_o), .rdy_o(rdy_o)
    );

    polar_kron_iter #(.MAX_LOG2N(8), .STG_PER_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .rdy_i(rdy_i3),
        .log2n_i(log2n_i), .brv_i(brv_i), .din(din),
        .dout(dout3), .vld_o(vld_o3), .rdy_o(rdy_o)
    );

    function automatic int rev(input int j, input int ln);
        int r;
        r = 0;
        for (int b = 0; b < ln; b++)
            if (((j >> b) & 1) == 1) r = r | (1 << (ln - 1 - b));
        return r;
    endfunction

    function automatic logic [NM-1:0] kron(input logic [NM-1:0] u,
                                           input int ln, input bit brv);
        logic [NM-1:0] x, y;
        int n;
        bit b;
        if (ln > 8) ln = 8;
        n = 1 << ln;
        x = '0;
        for (int j = 0; j < n; j++) begin
            b = 1'b0;
            for (int i = 0; i < n; i++)
                if ((i & j) == i) b = b ^ u[i];
            x[j] = b;
        end
        if (!brv) return x;
        y = '0;
        for (int j = 0; j < n; j++) y[rev(j, ln)] = x[j];
        return y;
    endfunction

    function automatic int kcyc(input int ln, input int spc);
        if (ln > 8) ln = 8;
        if (ln == 0) return 1;
        return (ln + spc - 1) / spc;
    endfunction

    function automatic logic [NM-1:0] rand256();
        logic [NM-1:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [NM-1:0] obs,
                       input logic [NM-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int ln, input bit brv, input logic [NM-1:0] d);
        int n;
        n = 0;
        while (!rdy_i && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("rdy_timeout", NM'(rdy_i), NM'(1));
        log2n_i = 4'(ln);
        brv_i   = brv;
        din     = d;
        vld_i   = 1'b1;
        @(posedge clk); #1;
        vld_i   = 1'b0;
        log2n_i = 4'($urandom);
        brv_i   = 1'($urandom);
        din     = rand256();
    endtask

    task automatic measure(output int l2, output logic [NM-1:0] d2,
                           output int l3, output logic [NM-1:0] d3);
        l2 = -1; l3 = -1; d2 = '0; d3 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (l2 < 0 && vld_o)  begin l2 = c; d2 = dout;  end
            if (l3 < 0 && vld_o3) begin l3 = c; d3 = dout3; end
            if (l2 >= 0 && l3 >= 0) break;
        end
    endtask

    initial begin
        int l2, l3, ln, cnt;
        bit brv;
        logic [NM-1:0] d2, d3, u, u2, hold;

        rst_n = 1'b0; vld_i = 1'b0; log2n_i = '0; brv_i = 1'b0;
        din = '0; rdy_o = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", NM'(vld_o), NM'(0));
        chk("rst_dout", dout, '0);
        chk("rst_rdy", NM'(rdy_i), NM'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(3, 0, NM'(8'h01)); measure(l2, d2, l3, d3);
        chk("ln3_u01", d2, NM'(8'hFF));
        chk("ln3_lat", NM'(l2), NM'(2));
        chk("ln3_u01_spc3", d3, NM'(8'hFF));

        send(3, 0, NM'(8'h0F)); measure(l2, d2, l3, d3);
        chk("ln3_u0f", d2, NM'(8'h11));
        send(3, 1, NM'(8'h0F)); measure(l2, d2, l3, d3);
        chk("ln3_u0f_brv", d2, NM'(8'h03));
        send(3, 0, NM'(8'h80)); measure(l2, d2, l3, d3);
        chk("ln3_u80", d2, NM'(8'h80));

        send(5, 0, '1); measure(l2, d2, l3, d3);
        chk("ln5_ones", d2, NM'(32'h0000_0001));
        chk("ln5_ones_model", d2, kron('1, 5, 0));

        repeat (3) @(posedge clk);
        #1;
        u = rand256();
        send(8, 0, u); measure(l2, d2, l3, d3);
        chk("ln8_rand", d2, kron(u, 8, 0));
        chk("ln8_lat", NM'(l2), NM'(4));
        chk("ln8_rand_spc3", d3, kron(u, 8, 0));
        chk("ln8_lat_spc3", NM'(l3), NM'(3));
        send(8, 0, d2); measure(l2, d2, l3, d3);
        chk("ln8_involution", d2, u);

        for (int t = 0; t < 6; t++) begin
            ln  = $urandom_range(0, 8);
            brv = 1'($urandom);
            u   = rand256();
            send(ln, brv, u); measure(l2, d2, l3, d3);
            chk($sformatf("rnd%0d_ln%0d_brv%0d", t, ln, brv), d2, kron(u, ln, brv));
            chk($sformatf("rnd%0d_lat", t), NM'(l2), NM'(kcyc(ln, 2)));
        end

        u = rand256();
        send(12, 0, u); measure(l2, d2, l3, d3);
        chk("ln12_clamp", d2, kron(u, 8, 0));
        chk("ln12_lat", NM'(l2), NM'(4));

        hold = d2;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_dout_hold", dout, hold);
        chk("idle_vld", NM'(vld_o), NM'(0));
        chk("idle_rdy", NM'(rdy_i), NM'(1));

        rdy_o = 1'b0;
        u = rand256();
        send(3, 0, u); measure(l2, d2, l3, d3);
        chk("bp_lat", NM'(l2), NM'(2));
        chk("bp_val", d2, kron(u, 3, 0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_vld", NM'(vld_o), NM'(1));
            chk("bp_dout", dout, d2);
            chk("bp_rdy", NM'(rdy_i), NM'(0));
        end
        u2 = rand256();
        log2n_i = 4'd3; brv_i = 1'b0; din = u2; vld_i = 1'b1; rdy_o = 1'b1;
        #1;
        chk("b2b_rdy", NM'(rdy_i), NM'(1));
        @(posedge clk); #1;
        vld_i = 1'b0;
        chk("b2b_vld_drop", NM'(vld_o), NM'(0));
        chk("b2b_run_rdy", NM'(rdy_i), NM'(0));
        measure(l2, d2, l3, d3);
        chk("b2b_lat", NM'(l2), NM'(2));
        chk("b2b_val", d2, kron(u2, 3, 0));

        repeat (2) @(posedge clk);
        #1;
        send(8, 0, rand256());
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", NM'(vld_o), NM'(0));
        chk("mid_rst_dout", dout, '0);
        chk("mid_rst_rdy", NM'(rdy_i), NM'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (vld_o) cnt++;
        end
        chk("post_rst_no_vld", NM'(cnt), NM'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
